ibus_fetch: RTL and testbench
=============================

# ibus_fetch

Instruction prefetch unit that masters the instruction bus. It issues sequential word fetches into the instruction bus interconnect and buffers returned words in a small FIFO for the decode stage. It handles control-flow redirects, including discarding a response that was already in flight, and turns an unmapped-address fault into a tagged FIFO entry.

## Interface
Parameters:
- `FIFO_DEPTH`, default 4: instruction buffer entries; power of two, at least 2.
- `RESET_ADDR`, default `` `RESET_ADDR ``: first fetch address after reset.

Ports (clock, reset first):
- `clk`  in  1  system clock.
- `rstn`  in  1  reset; one clock, asynchronous, active-low.
- `m_req`  out  1  bus request; held high until the transfer completes.
- `m_addr`  out  `` `XLEN ``  fetch address; bits [1:0] always 0.
- `m_w_rb`  out  1  constant 0 (read).
- `m_acc`  out  `` $clog2(`BUS_ACC_CNT) ``  constant `` `BUS_ACC_4B ``.
- `m_wdata`  out  `` `BUS_WIDTH ``  constant 0.
- `m_resp`  in  1  one-cycle response strobe.
- `m_rdata`  in  `` `BUS_WIDTH ``  read data, valid while `m_resp`=1.
- `bus_fault`  in  1  combinational; high in the same cycle as an unmapped `m_req`.
- `redir_valid`  in  1  redirect request.
- `redir_addr`  in  `` `XLEN ``  redirect target; bits [1:0] ignored.
- `out_valid`  out  1  FIFO head valid.
- `out_ready`  in  1  decode accepts the head.
- `out_instr`  out  `` `BUS_WIDTH ``  instruction word.
- `out_pc`  out  `` `XLEN ``  address of `out_instr`.
- `out_fault`  out  1  head entry is a bus fault; `out_instr` is 0.

## Operation
- Transfer completion: completion is defined as `m_req & (m_resp | bus_fault)`.
- States:
  - FETCH: `m_req`=1.
  - STALL: `m_req`=0 because the FIFO is full.
  - DRAIN: stale transfer outstanding; `m_req`=1, old address held.
  - HALT: `m_req`=0 after a fault.
- Issue rule: a new request is raised only when FIFO occupancy after this edge, including a write from the current completion and a pop from `out_ready & out_valid`, is below `FIFO_DEPTH`. At most one transfer is outstanding.
- FETCH on completion:
  - If `m_resp`: push {pc, rdata, fault=0} and set pc += 4. Stay in FETCH if the issue rule allows, otherwise go to STALL.
  - If `bus_fault`: push {pc, 0, fault=1} and go to HALT.
- STALL: move to FETCH when the issue rule allows.
- HALT: `m_req` stays 0 until a redirect.
- Redirect, highest priority, applies in every state:
  - Clear the FIFO at the edge; `out_valid`=0 the next cycle.
  - Set pc to {`redir_addr`[XLEN-1:2], 2'b00}.
  - If a transfer is outstanding and does not complete this cycle, go to DRAIN with the new pc pending.
  - Otherwise go to FETCH; a completion in the same cycle is discarded.
- DRAIN:
  - On completion, discard the data or fault; no push. Go to FETCH with the pending pc.
  - A redirect while in DRAIN only overwrites the pending pc.
- Address arithmetic: `m_addr` wraps modulo 2^XLEN (0xFFFF_FFFC + 4 = 0).
- FIFO simultaneous push and pop when full: not reachable because of the issue rule.
- FIFO simultaneous push and pop when empty: the push lands and `out_valid`=1 the next cycle. There is no bypass.
- Reset: asynchronous.
  - `m_req`=0, `m_addr`=`RESET_ADDR`, `out_valid`=0, `out_instr`=0, `out_pc`=0, `out_fault`=0, FIFO empty.
  - State is FETCH, so `m_req` rises in the first cycle after `rstn` deasserts.
  - Reset mid-transfer drops the transfer with no drain; the slave is reset alongside.

## Timing
- `m_req`, `m_addr`, `out_*` are registered outputs.
- `m_addr` changes only at a completion edge or a redirect edge.
- Back-to-back fetch: with a single-cycle slave, `m_req` stays high and one word completes per cycle.
- Response to output: `m_resp` at cycle K gives the entry at the FIFO head at K+1 (if the FIFO was empty).
- Redirect at edge N with no transfer outstanding: `m_req`=1 with the new address in cycle N+1.
- Redirect with a transfer outstanding: the new address appears in the cycle after the stale completion.
- Fault: HALT is entered at the completion edge; `m_req`=0 from the next cycle.

## Structure
- `femto.vh` gains `` `RESET_ADDR `` and `` `BUS_ACC_4B ``.
- State encoding is a localparam within the module.
- Sub-module `sync_fifo` (parameters `WIDTH`, `DEPTH`) provides push, pop, flush, count and a registered head. It is reusable by other buffering blocks.

## Test plan
- Reset release with a single-cycle ROM at 0x0000_0000: `m_addr` sequence 0x0, 0x4, 0x8 with `m_req` continuously high. `out_pc` 0x0 appears one cycle after the first `m_resp`.
- `out_ready`=0, FIFO_DEPTH=4: exactly 4 completions, then `m_req`=0. One pop leads to `m_req`=1 at the next address the following cycle.
- Slave with 3-cycle latency, redirect to 0x100 one cycle after `m_req` rises: the stale response is dropped and never appears on `out_*`. Next `m_addr`=0x100; the first `out_pc`=0x100.
- Redirect in the same cycle as `m_resp`: the response is discarded and `m_req`=1 with `redir_addr` in the next cycle.
- Fetch at an unmapped 0x7000_0000 (`bus_fault`=1): one entry with `out_fault`=1, `out_pc`=0x7000_0000, then `m_req`=0 indefinitely. A redirect to 0x0 resumes fetching.
- pc=0xFFFF_FFFC completes: the next `m_addr`=0x0000_0000. `redir_addr`=0x103 gives `m_addr`=0x100.

Source files
------------

// File: rtl/ibus_fetch_pkg.sv
// Shared types and constants for the instruction prefetch unit.
// Bus geometry mirrors the system header values used by the interconnect.
package ibus_fetch_pkg;

  localparam int XLEN        = 32;
  localparam int BUS_WIDTH   = 32;
  localparam int BUS_ACC_CNT = 3;
  localparam int ACC_W       = $clog2(BUS_ACC_CNT);

  localparam logic [ACC_W-1:0] BUS_ACC_4B     = ACC_W'(2);
  localparam logic [XLEN-1:0]  RESET_ADDR_DEF = '0;

  typedef struct packed {
    logic [XLEN-1:0]      pc;
    logic [BUS_WIDTH-1:0] instr;
    logic                 fault;
  } fetch_entry_t;

  function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] a);
    return a & ~XLEN'(3);
  endfunction

  // Wraps modulo 2^XLEN by plain truncation.
  function automatic logic [XLEN-1:0] next_pc(input logic [XLEN-1:0] a);
    return a + XLEN'(4);
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Shift-register FIFO: entry 0 is the registered head, flush empties it in one edge.
// Push into a full FIFO without a pop is the caller's responsibility to avoid.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rstn,
  input  logic                       i_push,
  input  logic [WIDTH-1:0]           i_wdata,
  input  logic                       i_pop,
  input  logic                       i_flush,
  output logic [$clog2(DEPTH+1)-1:0] o_count,
  output logic [WIDTH-1:0]           o_head,
  output logic                       o_valid
);

  localparam int CW = $clog2(DEPTH+1);

  logic [DEPTH-1:0][WIDTH-1:0] r_mem;
  logic [DEPTH-1:0][WIDTH-1:0] w_mem_nxt;
  logic [CW-1:0]               r_count;
  logic [CW-1:0]               w_count_nxt;
  logic [CW-1:0]               w_wpos;
  logic                        w_pop;
  logic                        r_valid;

  assign w_pop  = i_pop & (r_count != '0);
  // Write slot accounts for the shift caused by a simultaneous pop.
  assign w_wpos = r_count - CW'(w_pop);

  always_comb begin
    w_mem_nxt = w_pop ? (r_mem >> WIDTH) : r_mem;
    for (int i = 0; i < DEPTH; i++) begin
      if (i_push && (w_wpos == CW'(i))) begin
        w_mem_nxt[i] = i_wdata;
      end
    end
  end

  always_comb begin
    w_count_nxt = r_count + CW'(i_push) - CW'(w_pop);
    if (i_flush) begin
      w_count_nxt = '0;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_mem   <= '0;
      r_count <= '0;
      r_valid <= 1'b0;
    end else begin
      if (!i_flush) begin
        r_mem <= w_mem_nxt;
      end
      r_count <= w_count_nxt;
      r_valid <= (w_count_nxt != '0);
    end
  end

  assign o_count = r_count;
  assign o_head  = r_mem[0];
  assign o_valid = r_valid;

endmodule

// File: rtl/ibus_fetch.sv
// Instruction prefetch: sequential word fetch into a small FIFO, with redirect,
// in-flight response discard and fault tagging.
module ibus_fetch
  import ibus_fetch_pkg::*;
#(
  parameter int              FIFO_DEPTH = 4,
  parameter logic [XLEN-1:0] RESET_ADDR = RESET_ADDR_DEF
) (
  input  logic                 clk,
  input  logic                 rstn,
  output logic                 m_req,
  output logic [XLEN-1:0]      m_addr,
  output logic                 m_w_rb,
  output logic [ACC_W-1:0]     m_acc,
  output logic [BUS_WIDTH-1:0] m_wdata,
  input  logic                 m_resp,
  input  logic [BUS_WIDTH-1:0] m_rdata,
  input  logic                 bus_fault,
  input  logic                 redir_valid,
  input  logic [XLEN-1:0]      redir_addr,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [BUS_WIDTH-1:0] out_instr,
  output logic [XLEN-1:0]      out_pc,
  output logic                 out_fault
);

  localparam int CW = $clog2(FIFO_DEPTH+1);

  typedef enum logic [1:0] {S_FETCH, S_STALL, S_DRAIN, S_HALT} state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic            r_req;
  logic            w_req_nxt;
  logic [XLEN-1:0] r_addr;
  logic [XLEN-1:0] w_addr_nxt;
  logic [XLEN-1:0] r_pend;
  logic [XLEN-1:0] w_pend_nxt;
  logic [XLEN-1:0] w_redir_pc;
  logic            w_done;
  logic            w_pop;
  logic            w_push;
  logic            w_room;
  logic            w_fifo_valid;
  logic [CW-1:0]   w_count;
  logic [CW:0]     w_cnt_after;
  fetch_entry_t    w_wentry;
  fetch_entry_t    w_head;

  assign w_done     = r_req & (m_resp | bus_fault);
  assign w_pop      = out_ready & w_fifo_valid;
  assign w_redir_pc = word_align(redir_addr);
  // Only a live (non-stale, non-redirected) completion lands in the buffer.
  assign w_push     = ~redir_valid & (r_state == S_FETCH) & w_done;

  assign w_wentry.pc    = r_addr;
  assign w_wentry.instr = bus_fault ? '0 : m_rdata;
  assign w_wentry.fault = bus_fault;

  // Occupancy after this edge decides whether another request may be raised.
  assign w_cnt_after = {1'b0, w_count} + (CW+1)'(w_push) - (CW+1)'(w_pop);
  assign w_room      = (w_cnt_after < (CW+1)'(FIFO_DEPTH));

  always_comb begin
    w_state_nxt = r_state;
    w_addr_nxt  = r_addr;
    w_pend_nxt  = r_pend;
    if (redir_valid) begin
      if (r_req && !w_done) begin
        w_state_nxt = S_DRAIN;
        w_pend_nxt  = w_redir_pc;
      end else begin
        w_state_nxt = S_FETCH;
        w_addr_nxt  = w_redir_pc;
      end
    end else begin
      case (r_state)
        S_FETCH: begin
          if (w_done) begin
            if (bus_fault) begin
              w_state_nxt = S_HALT;
            end else begin
              w_addr_nxt  = next_pc(r_addr);
              w_state_nxt = w_room ? S_FETCH : S_STALL;
            end
          end
        end
        S_STALL: begin
          if (w_room) begin
            w_state_nxt = S_FETCH;
          end
        end
        S_DRAIN: begin
          if (w_done) begin
            w_state_nxt = S_FETCH;
            w_addr_nxt  = r_pend;
          end
        end
        default: begin
          w_state_nxt = r_state;
        end
      endcase
    end
    w_req_nxt = (w_state_nxt == S_FETCH) || (w_state_nxt == S_DRAIN);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state <= S_FETCH;
      r_req   <= 1'b0;
      r_addr  <= RESET_ADDR;
      r_pend  <= RESET_ADDR;
    end else begin
      r_state <= w_state_nxt;
      r_req   <= w_req_nxt;
      r_addr  <= w_addr_nxt;
      r_pend  <= w_pend_nxt;
    end
  end

  sync_fifo #(
    .WIDTH ($bits(fetch_entry_t)),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rstn    (rstn),
    .i_push  (w_push),
    .i_wdata (w_wentry),
    .i_pop   (w_pop),
    .i_flush (redir_valid),
    .o_count (w_count),
    .o_head  (w_head),
    .o_valid (w_fifo_valid)
  );

  assign m_req     = r_req;
  assign m_addr    = r_addr;
  assign m_w_rb    = 1'b0;
  assign m_acc     = BUS_ACC_4B;
  assign m_wdata   = '0;
  assign out_valid = w_fifo_valid;
  assign out_instr = w_head.instr;
  assign out_pc    = w_head.pc;
  assign out_fault = w_head.fault;

endmodule

// File: tb/tb_ibus_fetch.sv
// Bench for ibus_fetch: bus slave with configurable latency, queue-based reference
// model of the prefetch buffer, directed scenarios plus randomized traffic.
module tb_ibus_fetch;
  import ibus_fetch_pkg::*;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        m_req;
  logic [31:0] m_addr;
  logic        m_w_rb;
  logic [ACC_W-1:0] m_acc;
  logic [31:0] m_wdata;
  logic        m_resp = 1'b0;
  logic [31:0] m_rdata = '0;
  logic        bus_fault = 1'b0;
  logic        redir_valid = 1'b0;
  logic [31:0] redir_addr = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_instr;
  logic [31:0] out_pc;
  logic        out_fault;

  always #5 clk = ~clk;

  ibus_fetch #(.FIFO_DEPTH(DEPTH), .RESET_ADDR(32'h0)) dut (
    .clk(clk), .rstn(rstn), .m_req(m_req), .m_addr(m_addr), .m_w_rb(m_w_rb),
    .m_acc(m_acc), .m_wdata(m_wdata), .m_resp(m_resp), .m_rdata(m_rdata),
    .bus_fault(bus_fault), .redir_valid(redir_valid), .redir_addr(redir_addr),
    .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr),
    .out_pc(out_pc), .out_fault(out_fault)
  );

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        fault;
  } ent_t;

  ent_t        q[$];
  bit          e_req, e_drain, e_halt;
  logic [31:0] e_addr, e_pend;
  int          slave_wait, slave_lat, lat_mode;
  bit          rand_mode, drv_ready;
  int          rdy_pct;
  int          n_chk = 0;
  int          n_fail = 0;

  function automatic logic [31:0] rom(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'hC0DE_1357;
  endfunction

  function automatic bit unmapped(input logic [31:0] a);
    return a[31:28] == 4'h7;
  endfunction

  function automatic logic [31:0] rand_target();
    case ($urandom_range(0, 3))
      0:       return 32'($urandom_range(0, 1023));
      1:       return 32'h7000_0000 | 32'($urandom_range(0, 63));
      2:       return 32'hFFFF_FFF0 | 32'($urandom_range(0, 15));
      default: return $urandom;
    endcase
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic new_lat();
    slave_lat = (lat_mode < 0) ? int'($urandom_range(0, 3)) : lat_mode;
  endtask

  task automatic compare_all();
    chk("m_req", 32'(m_req), 32'(e_req));
    chk("m_addr", m_addr, e_addr);
    chk("out_valid", 32'(out_valid), 32'(q.size() > 0));
    if (q.size() > 0) begin
      chk("out_pc", out_pc, q[0].pc);
      chk("out_instr", out_instr, q[0].instr);
      chk("out_fault", 32'(out_fault), 32'(q[0].fault));
    end
    chk("m_w_rb", 32'(m_w_rb), 32'd0);
    chk("m_acc", 32'(m_acc), 32'd2);
    chk("m_wdata", m_wdata, 32'd0);
  endtask

  // Drives this cycle's inputs, advances the slave, and moves the model to the
  // state the DUT must show after the coming clock edge.
  task automatic drive_step(input bit rd, input logic [31:0] ra);
    bit flt, resp, rdy, done, pop;
    bit r = rd;
    logic [31:0] a = ra;
    if (rand_mode) begin
      rdy = ($urandom_range(0, 99) < rdy_pct);
      if ($urandom_range(0, 15) == 0) begin
        r = 1'b1;
        a = rand_target();
      end
    end else begin
      rdy = drv_ready;
    end
    flt  = m_req && unmapped(m_addr);
    resp = m_req && !flt && (slave_wait >= slave_lat);
    m_resp      = resp;
    bus_fault   = flt;
    m_rdata     = resp ? rom(m_addr) : $urandom;
    redir_valid = r;
    redir_addr  = a;
    out_ready   = rdy;
    if (resp || flt) begin
      slave_wait = 0;
      new_lat();
    end else if (m_req) begin
      slave_wait++;
    end

    done = e_req && (resp || flt);
    pop  = rdy && (q.size() > 0);
    if (r) begin
      q.delete();
      if (e_req && !done) begin
        e_drain = 1'b1;
        e_pend  = a & ~32'h3;
      end else begin
        e_drain = 1'b0;
        e_halt  = 1'b0;
        e_addr  = a & ~32'h3;
        e_req   = 1'b1;
      end
    end else begin
      if (pop) void'(q.pop_front());
      if (done) begin
        if (e_drain) begin
          e_drain = 1'b0;
          e_addr  = e_pend;
          e_req   = 1'b1;
        end else if (flt) begin
          q.push_back('{e_addr, 32'h0, 1'b1});
          e_halt = 1'b1;
          e_req  = 1'b0;
        end else begin
          q.push_back('{e_addr, rom(e_addr), 1'b0});
          e_addr = e_addr + 32'd4;
          e_req  = (q.size() < DEPTH);
        end
      end else if (!e_req && !e_halt) begin
        e_req = (q.size() < DEPTH);
      end
    end
  endtask

  task automatic tick(input bit rd = 1'b0, input logic [31:0] ra = 32'h0);
    @(negedge clk);
    compare_all();
    drive_step(rd, ra);
  endtask

  task automatic do_reset();
    rstn        = 1'b0;
    m_resp      = 1'b0;
    bus_fault   = 1'b0;
    redir_valid = 1'b0;
    out_ready   = 1'b0;
    q.delete();
    e_req   = 1'b0;
    e_drain = 1'b0;
    e_halt  = 1'b0;
    e_addr  = 32'h0;
    e_pend  = 32'h0;
    slave_wait = 0;
    new_lat();
    repeat (2) @(negedge clk);
    chk("rst_m_req", 32'(m_req), 32'd0);
    chk("rst_m_addr", m_addr, 32'h0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_instr", out_instr, 32'h0);
    chk("rst_out_pc", out_pc, 32'h0);
    chk("rst_out_fault", 32'(out_fault), 32'd0);
    rstn = 1'b1;
    drive_step(1'b0, 32'h0);
  endtask

  initial begin
    rand_mode = 1'b0;
    rdy_pct   = 50;

    // Single-cycle ROM from reset, decode not accepting: fill then stall.
    lat_mode = 0; drv_ready = 1'b0;
    do_reset();
    tick(); chk("A_req0", 32'(m_req), 32'd1); chk("A_addr0", m_addr, 32'h0);
    tick(); chk("A_req1", 32'(m_req), 32'd1); chk("A_addr1", m_addr, 32'h4);
    chk("A_first_valid", 32'(out_valid), 32'd1); chk("A_first_pc", out_pc, 32'h0);
    tick(); chk("A_req2", 32'(m_req), 32'd1); chk("A_addr2", m_addr, 32'h8);
    tick(); chk("A_addr3", m_addr, 32'hC);
    repeat (3) begin
      tick(); chk("A_stall", 32'(m_req), 32'd0);
    end
    drv_ready = 1'b1;
    tick();
    drv_ready = 1'b0;
    tick(); chk("A_resume_req", 32'(m_req), 32'd1); chk("A_resume_addr", m_addr, 32'h10);

    // 3-cycle slave, redirect one cycle after the request rises.
    lat_mode = 3; drv_ready = 1'b1;
    do_reset();
    tick();
    tick(1'b1, 32'h100);
    tick(); chk("B_hold_addr", m_addr, 32'h0); chk("B_hold_req", 32'(m_req), 32'd1);
    tick();
    tick(); chk("B_new_addr", m_addr, 32'h100); chk("B_no_stale", 32'(out_valid), 32'd0);
    repeat (3) tick();
    tick(); chk("B_first_valid", 32'(out_valid), 32'd1); chk("B_first_pc", out_pc, 32'h100);

    // Redirect coinciding with a response.
    lat_mode = 0; drv_ready = 1'b1;
    do_reset();
    tick(1'b1, 32'h40);
    tick(); chk("C_addr", m_addr, 32'h40); chk("C_req", 32'(m_req), 32'd1);
    chk("C_discard", 32'(out_valid), 32'd0);

    // Unmapped fetch: one tagged entry, then halt until redirect.
    lat_mode = 0; drv_ready = 1'b0;
    do_reset();
    tick(1'b1, 32'h7000_0000);
    tick(); chk("D_addr", m_addr, 32'h7000_0000);
    tick(); chk("D_valid", 32'(out_valid), 32'd1); chk("D_fault", 32'(out_fault), 32'd1);
    chk("D_pc", out_pc, 32'h7000_0000); chk("D_instr", out_instr, 32'h0);
    chk("D_req", 32'(m_req), 32'd0);
    repeat (6) begin
      tick(); chk("D_halt", 32'(m_req), 32'd0);
    end
    tick(1'b1, 32'h0);
    tick(); chk("D_resume_req", 32'(m_req), 32'd1); chk("D_resume_addr", m_addr, 32'h0);
    chk("D_flushed", 32'(out_valid), 32'd0);

    // Address wrap and redirect low-bit masking.
    lat_mode = 0; drv_ready = 1'b1;
    do_reset();
    tick(1'b1, 32'hFFFF_FFFC);
    tick(); chk("E_top_addr", m_addr, 32'hFFFF_FFFC);
    tick(1'b1, 32'h103); chk("E_wrap_addr", m_addr, 32'h0); chk("E_wrap_pc", out_pc, 32'hFFFF_FFFC);
    tick(); chk("E_mask_addr", m_addr, 32'h100);

    // Randomized traffic with random latency, backpressure and redirects.
    rand_mode = 1'b1; lat_mode = -1;
    rdy_pct = 30;
    do_reset();
    repeat (1500) tick();
    rdy_pct = 80;
    do_reset();
    repeat (1500) tick();
    rand_mode = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
